// File: rtl/interrupt_ack_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer_if
//   Signal bundle between the 8259 interrupt acknowledge sequencer and the
//   rest of the controller (IRR block, command decoder, CPU pins).
//
//   slave  : the sequencer itself (consumes IRR/mask/config/INTA#, drives
//            INT, freeze, IRR clear, ISR and the vector byte).
//   master : whatever surrounds the sequencer (IRR, decoder, CPU model).
//
//   Signals
//     interrupt_request_register  IRR contents
//     interrupt_mask              OCW1 mask, 1 = masked
//     auto_eoi_config             ICW4 AEOI bit
//     interrupt_vector_base       ICW2 T7..T3
//     end_of_interrupt            one-cycle one-hot ISR clear pulse
//     interrupt_acknowledge_n     INTA#, already synchronous
//     interrupt                   INT pin to the CPU
//     freeze                      hold IRR during acknowledge
//     clear_interrupt_request     one-cycle one-hot IRR clear
//     in_service_register         ISR
//     data_bus_out                vector byte
//     data_bus_output_enable      1 = drive data_bus_out
// -----------------------------------------------------------------------------
interface interrupt_ack_sequencer_if #(
  parameter int VECTOR_BASE_WIDTH = 5
);
  logic [7:0]                   interrupt_request_register;
  logic [7:0]                   interrupt_mask;
  logic                         auto_eoi_config;
  logic [VECTOR_BASE_WIDTH-1:0] interrupt_vector_base;
  logic [7:0]                   end_of_interrupt;
  logic                         interrupt_acknowledge_n;
  logic                         interrupt;
  logic                         freeze;
  logic [7:0]                   clear_interrupt_request;
  logic [7:0]                   in_service_register;
  logic [7:0]                   data_bus_out;
  logic                         data_bus_output_enable;

  modport slave (
    input  interrupt_request_register,
    input  interrupt_mask,
    input  auto_eoi_config,
    input  interrupt_vector_base,
    input  end_of_interrupt,
    input  interrupt_acknowledge_n,
    output interrupt,
    output freeze,
    output clear_interrupt_request,
    output in_service_register,
    output data_bus_out,
    output data_bus_output_enable
  );

  modport master (
    output interrupt_request_register,
    output interrupt_mask,
    output auto_eoi_config,
    output interrupt_vector_base,
    output end_of_interrupt,
    output interrupt_acknowledge_n,
    input  interrupt,
    input  freeze,
    input  clear_interrupt_request,
    input  in_service_register,
    input  data_bus_out,
    input  data_bus_output_enable
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//   Runs the 8259 8086-mode acknowledge: resolves fixed priority (IR0 highest)
//   over unmasked requests against the ISR, raises INT, and on the two INTA#
//   pulses freezes/clears the IRR, sets the ISR bit and presents the vector.
//   Handles commanded EOI and automatic EOI. All outputs are registered.
//
//   Ports
//     clock   system clock, rising edge
//     reset   synchronous, active-high (ICW1 write)
//     bus     interrupt_ack_sequencer_if.slave (see interface for signals)
//
//   State table
//     state | meaning
//     IDLE  | no request pending toward the CPU
//     REQ   | INT asserted, waiting for the first INTA# fall
//     ACK1  | first INTA# pulse low, IRR frozen, index latched
//     WAIT2 | between pulses, waiting for the second INTA# fall
//     ACK2  | second INTA# pulse low, vector on the bus
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer #(
  parameter int VECTOR_BASE_WIDTH = 5,
  parameter int SPURIOUS_LEVEL    = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  interrupt_ack_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

  localparam logic [2:0] SPURIOUS_IDX = 3'(SPURIOUS_LEVEL);

  state_t     state_q, state_nxt;
  logic       prev_n_q;
  logic [2:0] ack_idx_q, ack_idx_nxt;
  logic       spurious_q, spurious_nxt;
  logic       int_q, int_nxt;
  logic       freeze_q, freeze_nxt;
  logic [7:0] clr_q, clr_nxt;
  logic [7:0] isr_q, isr_nxt;
  logic [7:0] dbo_q, dbo_nxt;
  logic       dboe_q, dboe_nxt;

  logic       fall, rise;
  logic [7:0] isr_limit, eligible, isr_set, isr_clr;
  logic       res_valid;
  logic [2:0] res_idx;
  logic [VECTOR_BASE_WIDTH-1:0] base;
  logic [7:0] vec_byte;

  assign base     = bus.interrupt_vector_base;
  assign vec_byte = 8'({base, ack_idx_q});

  assign fall = prev_n_q & ~bus.interrupt_acknowledge_n;
  assign rise = ~prev_n_q & bus.interrupt_acknowledge_n;

  // Only levels strictly above the highest-priority in-service level may
  // interrupt; an empty ISR leaves every level open.
  always_comb begin
    isr_limit = 8'hFF;
    for (int i = 7; i >= 0; i--)
      if (isr_q[i]) isr_limit = (8'd1 << i) - 8'd1;
    eligible  = bus.interrupt_request_register & ~bus.interrupt_mask & isr_limit;
    res_valid = |eligible;
    res_idx   = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (eligible[i]) res_idx = 3'(i);
  end

  always_comb begin
    state_nxt    = state_q;
    ack_idx_nxt  = ack_idx_q;
    spurious_nxt = spurious_q;
    int_nxt      = int_q;
    freeze_nxt   = freeze_q;
    dbo_nxt      = dbo_q;
    dboe_nxt     = dboe_q;
    clr_nxt      = 8'h00;
    isr_set      = 8'h00;
    isr_clr      = 8'h00;

    case (state_q)
      IDLE: begin
        if (res_valid) begin
          int_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (fall) begin
          int_nxt    = 1'b0;
          freeze_nxt = 1'b1;
          state_nxt  = ACK1;
          if (res_valid) begin
            ack_idx_nxt  = res_idx;
            spurious_nxt = 1'b0;
            clr_nxt      = 8'd1 << res_idx;
            isr_set      = 8'd1 << res_idx;
          end else begin
            // Request vanished exactly at the acknowledge: report the
            // spurious level without touching IRR or ISR.
            ack_idx_nxt  = SPURIOUS_IDX;
            spurious_nxt = 1'b1;
          end
        end else if (!res_valid) begin
          int_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      ACK1: begin
        if (rise) state_nxt = WAIT2;
      end
      WAIT2: begin
        if (fall) begin
          dbo_nxt   = vec_byte;
          dboe_nxt  = 1'b1;
          state_nxt = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          dbo_nxt    = 8'h00;
          dboe_nxt   = 1'b0;
          freeze_nxt = 1'b0;
          if (bus.auto_eoi_config && !spurious_q) isr_clr = 8'd1 << ack_idx_q;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Acknowledge set takes precedence over a same-cycle EOI of that bit.
    isr_nxt = (isr_q & ~bus.end_of_interrupt & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_n_q   <= 1'b1;
      ack_idx_q  <= 3'd0;
      spurious_q <= 1'b0;
      int_q      <= 1'b0;
      freeze_q   <= 1'b0;
      clr_q      <= 8'h00;
      isr_q      <= 8'h00;
      dbo_q      <= 8'h00;
      dboe_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      prev_n_q   <= bus.interrupt_acknowledge_n;
      ack_idx_q  <= ack_idx_nxt;
      spurious_q <= spurious_nxt;
      int_q      <= int_nxt;
      freeze_q   <= freeze_nxt;
      clr_q      <= clr_nxt;
      isr_q      <= isr_nxt;
      dbo_q      <= dbo_nxt;
      dboe_q     <= dboe_nxt;
    end
  end

  assign bus.interrupt               = int_q;
  assign bus.freeze                  = freeze_q;
  assign bus.clear_interrupt_request = clr_q;
  assign bus.in_service_register     = isr_q;
  assign bus.data_bus_out            = dbo_q;
  assign bus.data_bus_output_enable  = dboe_q;

endmodule
